// File: rtl/cp0_if.sv
// Pipeline <-> CP0 signal bundle: mfc0/mtc0 access, M-stage exception
// inputs, interrupt lines, and the redirect/status outputs.
interface cp0_if;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] DIn;
  logic        We;
  logic [31:0] PC_M;
  logic        BD_M;
  logic        Exc_M;
  logic [4:0]  ExcCode_M;
  logic        Eret_M;
  logic [5:0]  HWInt;
  logic [31:0] DOut;
  logic [31:0] EPC;
  logic [31:0] HandlerPC;
  logic        IntReq;
  logic        EXL;

  // Pipeline side drives requests and observes CP0 state.
  modport master (
    output A1, A2, DIn, We, PC_M, BD_M, Exc_M, ExcCode_M, Eret_M, HWInt,
    input  DOut, EPC, HandlerPC, IntReq, EXL
  );

  // CP0 side.
  modport slave (
    input  A1, A2, DIn, We, PC_M, BD_M, Exc_M, ExcCode_M, Eret_M, HWInt,
    output DOut, EPC, HandlerPC, IntReq, EXL
  );
endinterface

// File: rtl/cp0.sv
// Coprocessor-0 exception sink: merges M-stage exceptions with hardware
// interrupts, commits SR/Cause/EPC and requests the handler redirect.
module cp0 #(
  parameter logic [31:0] PRID    = 32'h0000_4D49,
  parameter logic [31:0] HANDLER = 32'h0000_4180
) (
  input logic   clk,
  input logic   reset,
  cp0_if.slave  bus
);

  logic [5:0]  sr_im;
  logic        sr_exl;
  logic        sr_ie;
  logic        cause_bd;
  logic [5:0]  cause_ip;
  logic [4:0]  cause_exc;
  logic [31:0] epc_q;

  logic        int_pend;
  logic        exc_pend;
  logic        int_req;
  logic [31:0] pc_aligned;
  logic [31:0] epc_next;

  // Pending-event decode and victim-PC computation.
  always_comb begin
    int_pend   = (|(bus.HWInt & sr_im)) & sr_ie & ~sr_exl;
    exc_pend   = bus.Exc_M & ~sr_exl;
    int_req    = int_pend | exc_pend;
    pc_aligned = bus.PC_M & ~32'h0000_0003;
    epc_next   = pc_aligned - (bus.BD_M ? 32'd4 : 32'd0);
  end

  // Register commit: handler entry overrides mtc0/eret; otherwise the
  // mtc0 write lands first and a paired eret then clears EXL.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_im     <= '0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= '0;
      cause_exc <= '0;
      epc_q     <= '0;
    end else begin
      cause_ip <= bus.HWInt;
      if (int_req) begin
        sr_exl    <= 1'b1;
        cause_bd  <= bus.BD_M;
        cause_exc <= int_pend ? 5'd0 : bus.ExcCode_M;
        epc_q     <= epc_next;
      end else begin
        if (bus.We && bus.A2 == 5'd12) begin
          sr_im  <= bus.DIn[15:10];
          sr_exl <= bus.DIn[1];
          sr_ie  <= bus.DIn[0];
        end
        if (bus.We && bus.A2 == 5'd14) begin
          epc_q <= bus.DIn;
        end
        if (bus.Eret_M) begin
          sr_exl <= 1'b0;
        end
      end
    end
  end

  // mfc0 read mux; reflects pre-edge state, no write bypass.
  always_comb begin
    bus.DOut = '0;
    case (bus.A1)
      5'd12:   bus.DOut = {16'b0, sr_im, 8'b0, sr_exl, sr_ie};
      5'd13:   bus.DOut = {cause_bd, 15'b0, cause_ip, 3'b0, cause_exc, 2'b0};
      5'd14:   bus.DOut = epc_q;
      5'd15:   bus.DOut = PRID;
      default: bus.DOut = '0;
    endcase
  end

  // Status and redirect outputs.
  always_comb begin
    bus.EPC       = epc_q;
    bus.HandlerPC = HANDLER;
    bus.IntReq    = int_req;
    bus.EXL       = sr_exl;
  end

endmodule

// File: tb/tb_cp0.sv
// Directed self-checking bench for cp0.
module tb_cp0;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  cp0_if bus();

  cp0 #(.PRID(32'h0000_4D49), .HANDLER(32'h0000_4180)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.A2 = 5'd0; bus.DIn = '0; bus.We = 1'b0;
    bus.BD_M = 1'b0; bus.Exc_M = 1'b0; bus.ExcCode_M = 5'd0;
    bus.Eret_M = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a);
    bus.A1 = a;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    bus.A1 = 5'd0; bus.PC_M = 32'h0; bus.HWInt = 6'b0;
    step(); step();
    reset = 1'b0;
    rd(5'd12);
    n_cmp++; if (bus.DOut !== 32'h0) begin n_bad++; $display("FAIL reset_sr got %h exp %h", bus.DOut, 32'h0); end
    rd(5'd13);
    n_cmp++; if (bus.DOut !== 32'h0) begin n_bad++; $display("FAIL reset_cause got %h exp %h", bus.DOut, 32'h0); end
    rd(5'd14);
    n_cmp++; if (bus.DOut !== 32'h0) begin n_bad++; $display("FAIL reset_epc got %h exp %h", bus.DOut, 32'h0); end
    rd(5'd15);
    n_cmp++; if (bus.DOut !== 32'h0000_4D49) begin n_bad++; $display("FAIL reset_prid got %h exp %h", bus.DOut, 32'h0000_4D49); end
    rd(5'd3);
    n_cmp++; if (bus.DOut !== 32'h0) begin n_bad++; $display("FAIL unimpl_read got %h exp %h", bus.DOut, 32'h0); end
    n_cmp++; if (bus.IntReq !== 1'b0) begin n_bad++; $display("FAIL reset_intreq got %b exp 0", bus.IntReq); end
    n_cmp++; if (bus.HandlerPC !== 32'h0000_4180) begin n_bad++; $display("FAIL handler_pc got %h exp %h", bus.HandlerPC, 32'h0000_4180); end
  endtask

  task automatic test_interrupt();
    bus.We = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_0401;
    step();
    idle();
    rd(5'd12);
    n_cmp++; if (bus.DOut !== 32'h0000_0401) begin n_bad++; $display("FAIL sr_write got %h exp %h", bus.DOut, 32'h0000_0401); end
    bus.HWInt = 6'b000001; bus.PC_M = 32'h0000_3010;
    #1;
    n_cmp++; if (bus.IntReq !== 1'b1) begin n_bad++; $display("FAIL int_same_cycle got %b exp 1", bus.IntReq); end
    step();
    rd(5'd13);
    n_cmp++; if (bus.DOut !== 32'h0000_0400) begin n_bad++; $display("FAIL int_cause got %h exp %h", bus.DOut, 32'h0000_0400); end
    n_cmp++; if (bus.EPC !== 32'h0000_3010) begin n_bad++; $display("FAIL int_epc got %h exp %h", bus.EPC, 32'h0000_3010); end
    n_cmp++; if (bus.EXL !== 1'b1) begin n_bad++; $display("FAIL int_exl got %b exp 1", bus.EXL); end
    n_cmp++; if (bus.IntReq !== 1'b0) begin n_bad++; $display("FAIL int_blocked got %b exp 0", bus.IntReq); end
    bus.HWInt = 6'b0;
    step();
  endtask

  task automatic test_exception_bd();
    bus.Eret_M = 1'b1;
    step();
    idle();
    n_cmp++; if (bus.EXL !== 1'b0) begin n_bad++; $display("FAIL eret_clear got %b exp 0", bus.EXL); end
    bus.Exc_M = 1'b1; bus.ExcCode_M = 5'd12; bus.BD_M = 1'b1; bus.PC_M = 32'h0000_3024;
    #1;
    n_cmp++; if (bus.IntReq !== 1'b1) begin n_bad++; $display("FAIL exc_intreq got %b exp 1", bus.IntReq); end
    step();
    idle();
    rd(5'd13);
    n_cmp++; if (bus.DOut !== 32'h8000_0030) begin n_bad++; $display("FAIL exc_cause got %h exp %h", bus.DOut, 32'h8000_0030); end
    n_cmp++; if (bus.EPC !== 32'h0000_3020) begin n_bad++; $display("FAIL exc_bd_epc got %h exp %h", bus.EPC, 32'h0000_3020); end
    bus.Exc_M = 1'b1; bus.ExcCode_M = 5'd10; bus.PC_M = 32'h0000_5000;
    #1;
    n_cmp++; if (bus.IntReq !== 1'b0) begin n_bad++; $display("FAIL nested_intreq got %b exp 0", bus.IntReq); end
    step();
    idle();
    rd(5'd13);
    n_cmp++; if (bus.DOut !== 32'h8000_0030) begin n_bad++; $display("FAIL nested_cause got %h exp %h", bus.DOut, 32'h8000_0030); end
    n_cmp++; if (bus.EPC !== 32'h0000_3020) begin n_bad++; $display("FAIL nested_epc got %h exp %h", bus.EPC, 32'h0000_3020); end
  endtask

  task automatic test_priority();
    bus.Eret_M = 1'b1;
    step();
    idle();
    bus.HWInt = 6'b000001; bus.Exc_M = 1'b1; bus.ExcCode_M = 5'd4;
    bus.PC_M = 32'h0000_3101;
    bus.We = 1'b1; bus.A2 = 5'd14; bus.DIn = 32'h0000_1234;
    step();
    idle();
    rd(5'd13);
    n_cmp++; if (bus.DOut !== 32'h0000_0400) begin n_bad++; $display("FAIL prio_cause got %h exp %h", bus.DOut, 32'h0000_0400); end
    n_cmp++; if (bus.EPC !== 32'h0000_3100) begin n_bad++; $display("FAIL prio_epc got %h exp %h", bus.EPC, 32'h0000_3100); end
    bus.HWInt = 6'b0;
    step();
  endtask

  task automatic test_eret();
    bus.We = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_0C03;
    step();
    idle();
    bus.HWInt = 6'b000010; bus.PC_M = 32'h0000_3200;
    #1;
    n_cmp++; if (bus.IntReq !== 1'b0) begin n_bad++; $display("FAIL eret_pre_intreq got %b exp 0", bus.IntReq); end
    bus.Eret_M = 1'b1;
    step();
    idle();
    n_cmp++; if (bus.EXL !== 1'b0) begin n_bad++; $display("FAIL eret_exl got %b exp 0", bus.EXL); end
    n_cmp++; if (bus.IntReq !== 1'b1) begin n_bad++; $display("FAIL eret_reint got %b exp 1", bus.IntReq); end
    step();
    n_cmp++; if (bus.EPC !== 32'h0000_3200) begin n_bad++; $display("FAIL eret_epc got %h exp %h", bus.EPC, 32'h0000_3200); end
    rd(5'd13);
    n_cmp++; if (bus.DOut !== 32'h0000_0800) begin n_bad++; $display("FAIL eret_cause got %h exp %h", bus.DOut, 32'h0000_0800); end
    bus.HWInt = 6'b0;
    step();
  endtask

  task automatic test_writes();
    bus.We = 1'b1; bus.A2 = 5'd13; bus.DIn = 32'hFFFF_FFFF;
    step();
    bus.A2 = 5'd15;
    step();
    idle();
    rd(5'd13);
    n_cmp++; if (bus.DOut !== 32'h0) begin n_bad++; $display("FAIL cause_ro got %h exp %h", bus.DOut, 32'h0); end
    rd(5'd15);
    n_cmp++; if (bus.DOut !== 32'h0000_4D49) begin n_bad++; $display("FAIL prid_ro got %h exp %h", bus.DOut, 32'h0000_4D49); end
    bus.We = 1'b1; bus.A2 = 5'd14; bus.DIn = 32'h0000_4000;
    rd(5'd14);
    n_cmp++; if (bus.DOut !== 32'h0000_3200) begin n_bad++; $display("FAIL epc_no_bypass got %h exp %h", bus.DOut, 32'h0000_3200); end
    step();
    idle();
    rd(5'd14);
    n_cmp++; if (bus.DOut !== 32'h0000_4000) begin n_bad++; $display("FAIL epc_write got %h exp %h", bus.DOut, 32'h0000_4000); end
  endtask

  task automatic test_back_to_back();
    bus.We = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_0003; bus.Eret_M = 1'b1;
    step();
    idle();
    rd(5'd12);
    n_cmp++; if (bus.DOut !== 32'h0000_0001) begin n_bad++; $display("FAIL mtc0_eret_pair got %h exp %h", bus.DOut, 32'h0000_0001); end
    bus.Exc_M = 1'b1; bus.ExcCode_M = 5'd5; bus.PC_M = 32'h0000_7000;
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if (bus.EXL !== 1'b0) begin n_bad++; $display("FAIL reset_mid_exl got %b exp 0", bus.EXL); end
    step();
    rd(5'd13);
    n_cmp++; if (bus.DOut !== 32'h0) begin n_bad++; $display("FAIL reset_mid_cause got %h exp %h", bus.DOut, 32'h0); end
    n_cmp++; if (bus.EPC !== 32'h0) begin n_bad++; $display("FAIL reset_mid_epc got %h exp %h", bus.EPC, 32'h0); end
    idle();
    reset = 1'b0;
    step();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_interrupt();
    test_exception_bd();
    test_priority();
    test_eret();
    test_writes();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
